gppm_mul_seq: RTL and testbench

GPPM_MUL_SEQ -- requirements
Module: gppm_mul_seq

---
 rtl/gppm_mul_seq.sv | 116 +++++++++++
 tb/tb_gppm_mul_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gppm_mul_seq.sv
// Sequential 3x3 multiplier that drives a GPPM register/ALU unit through
// repeated addition, one instruction per state.
module gppm_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_SUB = 4'b0001,
  parameter logic [4:0] R_A    = 5'd0,
  parameter logic [4:0] R_B    = 5'd1,
  parameter logic [4:0] R_ACC  = 5'd2,
  parameter logic [4:0] R_ONE  = 5'd3,
  parameter logic [4:0] R_ZERO = 5'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  num1,
  input  logic [2:0]  num2,
  input  logic [31:0] gppm_out,
  input  logic        is_zero,
  output logic [63:0] instruction,
  output logic        busy,
  output logic        done,
  output logic [5:0]  product
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_A, S_LD_B, S_LD_ONE, S_LD_ZERO, S_LD_ACC,
    S_CHECK, S_ACCUM, S_DEC, S_RESULT, S_DONE
  } state_t;

  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic [5:0] r_product;
  logic       w_unused;

  // Only the low six bits carry the product; the rest of the ALU word is dropped.
  assign w_unused = ^gppm_out[31:6];

  function automatic logic [63:0] pack_instr(
    input logic [4:0] src_a, input logic [4:0] src_b, input logic [4:0] dst,
    input logic [3:0] op, input logic sel, input logic we, input logic [2:0] imm
  );
    logic [63:0] w;
    w        = '0;
    w[5:1]   = src_a;
    w[10:6]  = src_b;
    w[15:11] = dst;
    w[19:16] = op;
    w[20]    = sel;
    w[21]    = we;
    w[24:22] = imm;
    return w;
  endfunction

  always_comb begin
    instruction = '0;
    case (r_state)
      S_LD_A:    instruction = pack_instr(5'd0, 5'd0, R_A,    4'd0, 1'b0, 1'b1, num1);
      S_LD_B:    instruction = pack_instr(5'd0, 5'd0, R_B,    4'd0, 1'b0, 1'b1, num2);
      S_LD_ONE:  instruction = pack_instr(5'd0, 5'd0, R_ONE,  4'd0, 1'b0, 1'b1, 3'd1);
      S_LD_ZERO: instruction = pack_instr(5'd0, 5'd0, R_ZERO, 4'd0, 1'b0, 1'b1, 3'd0);
      S_LD_ACC:  instruction = pack_instr(5'd0, 5'd0, R_ACC,  4'd0, 1'b0, 1'b1, 3'd0);
      S_CHECK:   instruction = pack_instr(R_B,   R_ZERO, 5'd0,  OP_ADD, 1'b1, 1'b0, 3'd0);
      S_ACCUM:   instruction = pack_instr(R_ACC, R_A,    R_ACC, OP_ADD, 1'b1, 1'b1, 3'd0);
      S_DEC:     instruction = pack_instr(R_B,   R_ONE,  R_B,   OP_SUB, 1'b1, 1'b1, 3'd0);
      S_RESULT:  instruction = pack_instr(R_ACC, R_ZERO, 5'd0,  OP_ADD, 1'b1, 1'b0, 3'd0);
      default:   instruction = '0;
    endcase
  end

  // busy/done are updated from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LD_A;
            r_busy  <= 1'b1;
          end
        end
        S_LD_A:    r_state <= S_LD_B;
        S_LD_B:    r_state <= S_LD_ONE;
        S_LD_ONE:  r_state <= S_LD_ZERO;
        S_LD_ZERO: r_state <= S_LD_ACC;
        S_LD_ACC:  r_state <= S_CHECK;
        S_CHECK:   r_state <= is_zero ? S_RESULT : S_ACCUM;
        S_ACCUM:   r_state <= S_DEC;
        S_DEC:     r_state <= S_CHECK;
        S_RESULT: begin
          r_state   <= S_DONE;
          r_product <= gppm_out[5:0];
          r_done    <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_gppm_mul_seq.sv
// Bench for gppm_mul_seq: a behavioural GPPM register file/ALU answers the
// instruction stream; products and timing are checked against num1*num2.
module tb_gppm_mul_seq;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [4:0] R_A    = 5'd0;
  localparam logic [4:0] R_B    = 5'd1;
  localparam logic [4:0] R_ACC  = 5'd2;
  localparam logic [4:0] R_ONE  = 5'd3;
  localparam logic [4:0] R_ZERO = 5'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  num1 = '0;
  logic [2:0]  num2 = '0;
  logic [31:0] gppm_out;
  logic        is_zero;
  logic [63:0] instruction;
  logic        busy;
  logic        done;
  logic [5:0]  product;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] regs [32];
  logic [25:0] garbage = '0;

  gppm_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num1(num1), .num2(num2),
    .gppm_out(gppm_out), .is_zero(is_zero), .instruction(instruction),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // GPPM unit: immediate or ALU result, committed at the edge ending the state.
  always_comb begin
    logic [31:0] a_v, b_v, alu;
    a_v = regs[instruction[5:1]];
    b_v = regs[instruction[10:6]];
    alu = (instruction[19:16] == OP_SUB) ? a_v - b_v : a_v + b_v;
    gppm_out = instruction[20] ? alu : {29'd0, instruction[24:22]};
    if (instruction[20] && !instruction[21] && instruction[5:1] == R_ACC)
      gppm_out = {gppm_out[31:6] ^ garbage, gppm_out[5:0]};
    is_zero = (gppm_out == 32'd0);
  end

  always @(posedge clk)
    if (instruction[21]) regs[instruction[15:11]] <= gppm_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_accum(input logic [63:0] ins);
    return ins[5:1] == R_ACC && ins[10:6] == R_A && ins[15:11] == R_ACC &&
           ins[19:16] == OP_ADD && ins[20] && ins[21];
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the idle
  // cycle following DONE.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input bit hold);
    int lat, accums;
    bit busy_ok, prod_held;
    logic [5:0] prev;
    prev = product;
    garbage = 26'($urandom);
    num1 = a; num2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("lda_fields", {59'd0, instruction[24:20]}, {59'd0, a, 2'b10});
    check("lda_dst", {59'd0, instruction[15:11]}, {59'd0, R_A});
    lat = 0; accums = 0; busy_ok = 1; prod_held = 1;
    while (!done && lat < 200) begin
      if (is_accum(instruction)) accums++;
      if (!busy) busy_ok = 0;
      if (product !== prev) prod_held = 0;
      if (lat >= 2) begin num1 = 3'($urandom); num2 = 3'($urandom); end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 200) $display("FAIL timeout: no done within 200 cycles for %0d x %0d", a, b);
    check("latency", 64'(lat), 64'(3 * int'(b) + 7));
    check("product", {58'd0, product}, 64'(int'(a) * int'(b)));
    check("accum_count", 64'(accums), 64'(b));
    check("busy_during_op", {63'd0, busy_ok}, 64'd1);
    check("product_held", {63'd0, prod_held}, 64'd1);
    check("busy_in_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_instr", instruction, 64'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 + i;
    reset_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_instr", instruction, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", {58'd0, product}, 64'd0);
    start = 1'b0;
    reset_n = 1'b1;

    run_op(3'd3, 3'd4, 1'b0);
    run_op(3'd7, 3'd7, 1'b0);

    // Abort a 2x5 run during ACCUM.
    num1 = 3'd2; num2 = 3'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!is_accum(instruction) && w < 50) begin @(negedge clk); w++; end
    check("reached_accum", {63'd0, is_accum(instruction)}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_instr", instruction, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", {58'd0, product}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", {63'd0, done}, 64'd0);
    end
    reset_n = 1'b1;
    run_op(3'd2, 3'd5, 1'b0);

    run_op(3'd5, 3'd0, 1'b0);
    run_op(3'd0, 3'd6, 1'b0);

    // Start held high: back-to-back runs with one idle cycle between them.
    run_op(3'd3, 3'd2, 1'b1);
    run_op(3'd6, 3'd5, 1'b1);
    start = 1'b0;

    for (int k = 0; k < 8; k++)
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), k[0]);
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
